// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes, RV32I opcode/funct3 values,
// immediate formats and the issue payload record.
package alu_pkg;

  localparam logic [3:0] CNTL_ADD  = 4'd0;
  localparam logic [3:0] CNTL_SLT  = 4'd1;
  localparam logic [3:0] CNTL_SLTU = 4'd2;
  localparam logic [3:0] CNTL_AND  = 4'd3;
  localparam logic [3:0] CNTL_OR   = 4'd4;
  localparam logic [3:0] CNTL_XOR  = 4'd5;
  localparam logic [3:0] CNTL_SLL  = 4'd6;
  localparam logic [3:0] CNTL_SRL  = 4'd7;
  localparam logic [3:0] CNTL_SUB  = 4'd8;
  localparam logic [3:0] CNTL_SRA  = 4'd9;
  localparam logic [3:0] CNTL_AM   = 4'd10;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_U, IMM_SH, IMM_FOUR} imm_t;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  cntl;
    logic        not_s;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] gen_imm(input imm_t sel, input logic [31:0] instr);
    case (sel)
      IMM_I:    gen_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:    gen_imm = {instr[31:12], 12'b0};
      IMM_SH:   gen_imm = {27'b0, instr[24:20]};
      IMM_FOUR: gen_imm = 32'd4;
      default:  gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decoder producing ALU operands and control.
// Optional AM custom-0 decode enabled by ALU_ISSUE_AM_EN.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output issue_t      dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic       shift_f7_ok;
  logic [3:0] cntl;
  logic       we;
  logic       illegal;
  logic [31:0] srca;
  imm_t       imm_sel;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign rd_field    = instr[11:7];
  assign shift_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  always_comb begin
    srca    = rs1_val;
    imm_sel = IMM_NONE;
    cntl    = CNTL_ADD;
    we      = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        we = 1'b1;
        case (funct3)
          F3_ADD:  cntl = funct7[5] ? CNTL_SUB : CNTL_ADD;
          F3_SLL:  cntl = CNTL_SLL;
          F3_SLT:  cntl = CNTL_SLT;
          F3_SLTU: cntl = CNTL_SLTU;
          F3_XOR:  cntl = CNTL_XOR;
          F3_SR:   cntl = funct7[5] ? CNTL_SRA : CNTL_SRL;
          F3_OR:   cntl = CNTL_OR;
          default: cntl = CNTL_AND;
        endcase
      end
      OPC_OPIMM: begin
        we      = 1'b1;
        imm_sel = IMM_I;
        case (funct3)
          F3_ADD:  cntl = CNTL_ADD;
          F3_SLL: begin
            cntl    = CNTL_SLL;
            imm_sel = IMM_SH;
            illegal = !shift_f7_ok;
          end
          F3_SLT:  cntl = CNTL_SLT;
          F3_SLTU: cntl = CNTL_SLTU;
          F3_XOR:  cntl = CNTL_XOR;
          F3_SR: begin
            cntl    = funct7[5] ? CNTL_SRA : CNTL_SRL;
            imm_sel = IMM_SH;
            illegal = !shift_f7_ok;
          end
          F3_OR:   cntl = CNTL_OR;
          default: cntl = CNTL_AND;
        endcase
      end
      OPC_LUI: begin
        srca    = '0;
        imm_sel = IMM_U;
        we      = 1'b1;
      end
      OPC_AUIPC: begin
        srca    = pc;
        imm_sel = IMM_U;
        we      = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        we      = 1'b1;
      end
      OPC_STORE: imm_sel = IMM_S;
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ, F3_BNE:   cntl = CNTL_SUB;
          F3_BLT, F3_BGE:   cntl = CNTL_SLT;
          F3_BLTU, F3_BGEU: cntl = CNTL_SLTU;
          default:          illegal = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        srca    = pc;
        imm_sel = IMM_FOUR;
        we      = 1'b1;
      end
`ifdef ALU_ISSUE_AM_EN
      OPC_CUSTOM0: begin
        if (funct3 == 3'b000) begin
          cntl = CNTL_AM;
          we   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
`endif
      default: illegal = 1'b1;
    endcase

    // Illegal encodings collapse to a harmless ADD of zeros with no writeback.
    if (illegal) begin
      dec.srca = '0;
      dec.srcb = '0;
      dec.cntl = CNTL_ADD;
      dec.we   = 1'b0;
    end else begin
      dec.srca = srca;
      dec.srcb = (imm_sel == IMM_NONE) ? rs2_val : gen_imm(imm_sel, instr);
      dec.cntl = cntl;
      dec.we   = we && (rd_field != 5'd0);
    end
    dec.not_s   = (dec.cntl != CNTL_SLTU);
    dec.rd      = dec.we ? rd_field : 5'd0;
    dec.illegal = illegal;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one-entry valid/ready register around alu_issue_dec with flush.
// Define ALU_ISSUE_AM_EN to decode custom-0 funct3=000 as the AM operation.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [3:0]  RST_CNTL = 4'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_srca,
  output logic [XLEN-1:0] out_srcb,
  output logic [3:0]      out_cntl,
  output logic            out_not_s,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  localparam issue_t RST_ENTRY = '{srca: '0, srcb: '0, cntl: RST_CNTL, not_s: 1'b1,
                                   rd: '0, we: 1'b0, illegal: 1'b0};

  issue_t dec;
  issue_t entry;
  logic   accept;

  alu_issue_dec u_dec (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .dec     (dec)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      entry     <= RST_ENTRY;
    end else if (accept) begin
      out_valid <= 1'b1;
      entry     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_srca    = entry.srca;
  assign out_srcb    = entry.srcb;
  assign out_cntl    = entry.cntl;
  assign out_not_s   = entry.not_s;
  assign out_rd      = entry.rd;
  assign out_we      = entry.we;
  assign out_illegal = entry.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected decode records are queued on accept
// and compared against the registered payload while it is presented.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  cntl;
    logic        not_s;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, out_srca, out_srcb;
  logic [3:0]  out_cntl;
  logic        out_not_s, out_we, out_illegal;
  logic [4:0]  out_rd;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb[$];

  alu_issue #(.XLEN(32), .RST_CNTL(4'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_srca(out_srca), .out_srcb(out_srcb),
    .out_cntl(out_cntl), .out_not_s(out_not_s), .out_rd(out_rd), .out_we(out_we),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                              input logic ns, input logic [4:0] rd, input logic we, input logic ill);
    mk = '{srca: a, srcb: b, cntl: c, not_s: ns, rd: rd, we: we, ill: ill};
  endfunction

  function automatic exp_t observed();
    observed = '{srca: out_srca, srcb: out_srcb, cntl: out_cntl, not_s: out_not_s,
                 rd: out_rd, we: out_we, ill: out_illegal};
  endfunction

  // Head of the scoreboard must be presented every cycle out_valid is high, so a
  // stalled entry that drifts is caught as well as a wrong one.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 76'(sb.size()), 76'd1);
      end else begin
        exp_t e, g;
        e = sb[0];
        g = observed();
        if (e.ill) begin
          g.srca = '0; g.srcb = '0;
        end
        check("payload", g, e);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    int unsigned n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_val = rs1; in_rs2_val = rs2;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 76'(in_ready), 76'd1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain", 76'(sb.size()), 76'd0);
  endtask

  initial begin
    exp_t rst_e;
    rst_e = mk(32'd0, 32'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
    in_rs1_val = 32'd5; in_rs2_val = 32'd7;

    // Reset held two cycles with a valid input present.
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_valid", 76'(out_valid), 76'd0);
      check("rst_payload", observed(), rst_e);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 76'(out_valid), 76'd0);
    check("post_rst_cntl", 76'(out_cntl), 76'd0);
    @(posedge clk); #1;

    // Back-to-back stream with out_ready high.
    send(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd0, 1'b1, 5'd3, 1'b1, 1'b0));
    send(32'h40415093, 32'h104, 32'h80000000, 32'd9, mk(32'h80000000, 32'd4, 4'd9, 1'b1, 5'd1, 1'b1, 1'b0));
    send(32'h0020E463, 32'h108, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'd2, 1'b0, 5'd0, 1'b0, 1'b0));
    send(32'h407302B3, 32'h10C, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'd8, 1'b1, 5'd5, 1'b1, 1'b0));
    send(32'hFFF00093, 32'h110, 32'd0, 32'd3, mk(32'd0, 32'hFFFFFFFF, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0));
    send(32'h123452B7, 32'h114, 32'h55, 32'd3, mk(32'd0, 32'h12345000, 4'd0, 1'b1, 5'd5, 1'b1, 1'b0));
    send(32'hFFFFF317, 32'h118, 32'h55, 32'd3, mk(32'h118, 32'hFFFFF000, 4'd0, 1'b1, 5'd6, 1'b1, 1'b0));
    send(32'h0020A423, 32'h11C, 32'h200, 32'd3, mk(32'h200, 32'd8, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0));
    send(32'hFE20AE23, 32'h120, 32'h200, 32'd3, mk(32'h200, 32'hFFFFFFFC, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0));
    send(32'hFF80A203, 32'h124, 32'h300, 32'd3, mk(32'h300, 32'hFFFFFFF8, 4'd0, 1'b1, 5'd4, 1'b1, 1'b0));
    send(32'h008000EF, 32'h128, 32'h1, 32'd3, mk(32'h128, 32'd4, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0));
    send(32'h00208033, 32'h12C, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0));
    send(32'h0020D463, 32'h130, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd1, 1'b1, 5'd0, 1'b0, 1'b0));
    send(32'h003130B3, 32'h134, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd2, 1'b0, 5'd1, 1'b1, 1'b0));
    send(32'h0020D1B3, 32'h138, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd7, 1'b1, 5'd3, 1'b1, 1'b0));
    send(32'h0020C1B3, 32'h13C, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd5, 1'b1, 5'd3, 1'b1, 1'b0));
    send(32'h0020F1B3, 32'h140, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd3, 1'b1, 5'd3, 1'b1, 1'b0));
    send(32'h0020A463, 32'h144, 32'd5, 32'd7, mk(32'd0, 32'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b1));
    send(32'h02111093, 32'h148, 32'd5, 32'd7, mk(32'd0, 32'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b1));
    send(32'h00000000, 32'h14C, 32'd5, 32'd7, mk(32'd0, 32'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b1));
`ifdef ALU_ISSUE_AM_EN
    send(32'h0020818B, 32'h150, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd10, 1'b1, 5'd3, 1'b1, 1'b0));
`else
    send(32'h0020818B, 32'h150, 32'd5, 32'd7, mk(32'd0, 32'd0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b1));
`endif
    drain();

    // Downstream stall with back-to-back input, then release.
    out_ready = 1'b0;
    fork
      begin
        send(32'h002091B3, 32'h200, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'd6, 1'b1, 5'd3, 1'b1, 1'b0));
        send(32'h0020A1B3, 32'h204, 32'd3, 32'd4, mk(32'd3, 32'd4, 4'd1, 1'b1, 5'd3, 1'b1, 1'b0));
        send(32'h0020E1B3, 32'h208, 32'd5, 32'd6, mk(32'd5, 32'd6, 4'd4, 1'b1, 5'd3, 1'b1, 1'b0));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 76'(in_ready), 76'd0);
        check("stall_valid", 76'(out_valid), 76'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush coincident with an accept.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 32'd9; in_rs2_val = 32'd9;
    @(negedge clk);
    check("flush_in_ready", 76'(in_ready), 76'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_acc_valid", 76'(out_valid), 76'd0);
    check("flush_acc_payload", observed(), rst_e);

    // Flush of an entry held by backpressure.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0020C1B3, 32'h300, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'd5, 1'b1, 5'd3, 1'b1, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_hold_valid", 76'(out_valid), 76'd0);
    check("flush_hold_payload", observed(), rst_e);
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
